// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
package pipe_pkg;
   localparam int DEF_PC_W    = 32;
   localparam int DEF_INSTR_W = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_t;
endpackage

// File: rtl/if_id_entry.sv
// One {valid, pc, instr} slot; clear wins over load and leaves a NOP behind.
module if_id_entry
   import pipe_pkg::*;
#(
   parameter int PC_W    = DEF_PC_W,
   parameter int INSTR_W = DEF_INSTR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               load,
   input  logic [PC_W-1:0]    d_pc,
   input  logic [INSTR_W-1:0] d_instr,
   output logic               valid,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= INSTR_W'(NOP_INSTR);
      end else if (clear) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= INSTR_W'(NOP_INSTR);
      end else if (load) begin
         valid <= 1'b1;
         pc    <= d_pc;
         instr <= d_instr;
      end
   end

endmodule

// File: rtl/if_id_pipe.sv
// IF->ID register with 2-entry skid: 1-cycle latency, in_ready depends only on state.
// Optional perf counters (stall/flush) enabled by IF_ID_PERF_CNT_EN.
module if_id_pipe
   import pipe_pkg::*;
#(
   parameter int PC_W    = DEF_PC_W,
   parameter int INSTR_W = DEF_INSTR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr
`ifdef IF_ID_PERF_CNT_EN
   ,
   output logic [31:0]        stall_cnt,
   output logic [31:0]        flush_cnt
`endif
);

   buf_state_t state, next_state;

   logic               accept, pop;
   logic               main_load, main_clear, main_from_skid;
   logic               skid_load, skid_clear;
   logic               main_valid, skid_valid;
   logic [PC_W-1:0]    main_pc, skid_pc, main_d_pc;
   logic [INSTR_W-1:0] main_instr, skid_instr, main_d_instr;

   assign in_ready  = (state != FULL);
   assign accept    = in_valid && in_ready;
   assign pop       = main_valid && out_ready;
   assign out_valid = main_valid;
   assign out_pc    = main_pc;
   assign out_instr = main_instr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= EMPTY;
      else     state <= next_state;
   end

   always_comb begin
      next_state     = state;
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush) begin
         next_state = EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  next_state = ONE;
                  main_load  = 1'b1;
               end
            end
            ONE: begin
               if (accept && !pop) begin
                  next_state = FULL;
                  skid_load  = 1'b1;
               end else if (accept && pop) begin
                  main_load  = 1'b1;
               end else if (pop) begin
                  next_state = EMPTY;
                  main_clear = 1'b1;
               end
            end
            FULL: begin
               // Skid moves up to main so ordering is preserved.
               if (pop) begin
                  next_state     = ONE;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_clear     = 1'b1;
               end
            end
            default: next_state = EMPTY;
         endcase
      end
   end

   assign main_d_pc    = main_from_skid ? skid_pc    : in_pc;
   assign main_d_instr = main_from_skid ? skid_instr : in_instr;

   if_id_entry #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_main (
      .clk     (clk),
      .rst     (rst),
      .clear   (main_clear),
      .load    (main_load),
      .d_pc    (main_d_pc),
      .d_instr (main_d_instr),
      .valid   (main_valid),
      .pc      (main_pc),
      .instr   (main_instr)
   );

   if_id_entry #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clear   (skid_clear),
      .load    (skid_load),
      .d_pc    (in_pc),
      .d_instr (in_instr),
      .valid   (skid_valid),
      .pc      (skid_pc),
      .instr   (skid_instr)
   );

`ifdef IF_ID_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (in_valid && !in_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
         if (flush && flush_cnt != 32'hFFFF_FFFF)                 flush_cnt <= flush_cnt + 32'd1;
      end
   end
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: directed scenarios then random traffic against a queue model.
module tb_if_id_pipe;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
`ifdef IF_ID_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   int total = 0;
   int bad   = 0;

   ent_t        q[$];
   logic [31:0] stall_exp = '0;
   logic [31:0] flush_exp = '0;

   always #5 clk = ~clk;

   if_id_pipe #(.PC_W(32), .INSTR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr)
`ifdef IF_ID_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   function automatic logic [31:0] mk_instr(input logic [31:0] pc);
      return pc ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic        ev;
      logic [31:0] ep, ei;
      ev = (q.size() != 0);
      ep = ev ? q[0].pc    : 32'h0;
      ei = ev ? q[0].instr : 32'h0;
      check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
      check({tag, ".out_pc"},    out_pc, ep);
      check({tag, ".out_instr"}, out_instr, ei);
      check({tag, ".in_ready"},  32'(in_ready), 32'(q.size() < 2));
`ifdef IF_ID_PERF_CNT_EN
      check({tag, ".stall_cnt"}, stall_cnt, stall_exp);
      check({tag, ".flush_cnt"}, flush_cnt, flush_exp);
`endif
   endtask

   // Drive one cycle, advance the model across the edge, then compare.
   task automatic step(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] instr, input logic ordy, input logic fl);
      logic rdy, acc, pp;
      in_valid  = v;
      in_pc     = pc;
      in_instr  = instr;
      out_ready = ordy;
      flush     = fl;
      rdy = (q.size() < 2);
      acc = v && rdy;
      pp  = (q.size() > 0) && ordy;
      if (v && !rdy && stall_exp != 32'hFFFF_FFFF) stall_exp = stall_exp + 32'd1;
      if (fl && flush_exp != 32'hFFFF_FFFF)         flush_exp = flush_exp + 32'd1;
      @(posedge clk);
      #1;
      if (fl) q.delete();
      else begin
         if (pp)  void'(q.pop_front());
         if (acc) q.push_back('{pc: pc, instr: instr});
      end
      check_model(tag);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_pc = '0; in_instr = '0;
   endtask

   initial begin
      // Reset
      #1 rst = 1'b1;
      q.delete(); stall_exp = '0; flush_exp = '0;
      #1;
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.out_pc",    out_pc, 32'd0);
      check("reset.out_instr", out_instr, 32'd0);
      check("reset.in_ready",  32'(in_ready), 32'd1);
`ifdef IF_ID_PERF_CNT_EN
      check("reset.stall_cnt", stall_cnt, 32'd0);
      check("reset.flush_cnt", flush_cnt, 32'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;

      // Streaming at full throughput
      for (int i = 0; i < 4; i++) begin
         step("stream", 1'b1, 32'(i * 4), mk_instr(32'(i * 4)), 1'b1, 1'b0);
         check("stream.pc_const", out_pc, 32'(i * 4));
         check("stream.rdy_const", 32'(in_ready), 32'd1);
      end
      step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("drain.valid_const", 32'(out_valid), 32'd0);

      // Backpressure into skid
      step("bp0", 1'b1, 32'h0, mk_instr(32'h0), 1'b1, 1'b0);
      step("bp4", 1'b1, 32'h4, mk_instr(32'h4), 1'b0, 1'b0);
      check("bp4.rdy_const", 32'(in_ready), 32'd0);
      check("bp4.pc_const", out_pc, 32'h0);
      step("bp8_hold", 1'b1, 32'h8, mk_instr(32'h8), 1'b0, 1'b0);
      check("bp8_hold.pc_const", out_pc, 32'h0);
      step("bp_rel1", 1'b1, 32'h8, mk_instr(32'h8), 1'b1, 1'b0);
      check("bp_rel1.pc_const", out_pc, 32'h4);
      step("bp_rel2", 1'b1, 32'h8, mk_instr(32'h8), 1'b1, 1'b0);
      check("bp_rel2.pc_const", out_pc, 32'h8);
      step("bp_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("bp_drain.valid_const", 32'(out_valid), 32'd0);

      // Flush while FULL with a competing fetch
      step("ff_fill1", 1'b1, 32'h10, mk_instr(32'h10), 1'b0, 1'b0);
      step("ff_fill2", 1'b1, 32'h14, mk_instr(32'h14), 1'b0, 1'b0);
      check("ff_full.rdy_const", 32'(in_ready), 32'd0);
      step("ff_flush", 1'b1, 32'h18, mk_instr(32'h18), 1'b1, 1'b1);
      check("ff_flush.valid_const", 32'(out_valid), 32'd0);
      check("ff_flush.instr_const", out_instr, 32'd0);
      check("ff_flush.rdy_const", 32'(in_ready), 32'd1);
      step("ff_after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("ff_after.valid_const", 32'(out_valid), 32'd0);

      // Flush with simultaneous accept from EMPTY
      step("fe_flush", 1'b1, 32'h20, mk_instr(32'h20), 1'b1, 1'b1);
      check("fe_flush.valid_const", 32'(out_valid), 32'd0);
      step("fe_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset while FULL, checked before the next edge
      step("ar_fill1", 1'b1, 32'h40, mk_instr(32'h40), 1'b0, 1'b0);
      step("ar_fill2", 1'b1, 32'h44, mk_instr(32'h44), 1'b0, 1'b0);
      idle_inputs();
      rst = 1'b1;
      q.delete(); stall_exp = '0; flush_exp = '0;
      #1;
      check("arst.out_valid", 32'(out_valid), 32'd0);
      check("arst.in_ready",  32'(in_ready), 32'd1);
      check("arst.out_pc",    out_pc, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      check_model("arst_rel");

      // Stall and flush counting (counters checked only when present)
      step("pc_fill1", 1'b1, 32'h30, mk_instr(32'h30), 1'b0, 1'b0);
      step("pc_fill2", 1'b1, 32'h34, mk_instr(32'h34), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("pc_stall", 1'b1, 32'h38, mk_instr(32'h38), 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) step("pc_flush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
`ifdef IF_ID_PERF_CNT_EN
      check("perf.stall_const", stall_cnt, 32'd5);
      check("perf.flush_const", flush_cnt, 32'd2);
`endif

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] pc;
         pc = $urandom & 32'hFFFF_FFFC;
         step("rand", ($urandom % 4) != 0, pc, $urandom, ($urandom % 3) != 0, ($urandom % 16) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_id_pipe.md
# if_id_pipe

Pipeline register between instruction fetch and instruction decode. It captures each fetched PC/instruction pair from the fetch stage and presents it to decode one cycle later. A 2-entry skid buffer gives decode full-throughput valid/ready backpressure with no combinational ready path. Taken-branch flushes squash in-flight fetches.

## Interface
Parameters:
- PC_W, 32, width of program counter
- INSTR_W, 32, width of instruction word

Ports. Clock is `clk`; reset `rst` is asynchronous, active-high.
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- flush  input  1  synchronous squash; driven by the branch-taken signal
- in_valid  input  1  fetch stage presents a PC/instruction pair
- in_ready  output  1  buffer can accept; fetch uses !in_ready as its freeze
- in_pc  input  PC_W  PC of the fetched instruction
- in_instr  input  INSTR_W  fetched instruction word
- out_valid  output  1  decode-side entry valid
- out_ready  input  1  decode consumes the entry this cycle
- out_pc  output  PC_W  PC of the head entry
- out_instr  output  INSTR_W  instruction of the head entry
- stall_cnt  output  32  stall-cycle counter (only with IF_ID_PERF_CNT_EN)
- flush_cnt  output  32  flush-cycle counter (only with IF_ID_PERF_CNT_EN)

## Operation
- Storage: main entry (drives out_*) and skid entry. Each entry holds {valid, pc, instr}.
- accept = in_valid && in_ready. pop = out_valid && out_ready.
- State machine:
  - EMPTY: no valid entries.
  - ONE: main valid only.
  - FULL: main and skid valid.
- Transitions from EMPTY:
  - accept → ONE, input written to main.
- Transitions from ONE:
  - accept && !pop → FULL, input written to skid.
  - accept && pop → ONE, input written to main.
  - pop && !accept → EMPTY.
- Transitions from FULL:
  - accept is impossible because in_ready is 0.
  - pop → ONE, skid copied to main.
- Entries are handed over in order. An entry is never overwritten while valid and not popped.
- flush has top priority. The next state is EMPTY, and any same-cycle accept or pop is discarded. Pop still counts as seen by decode; decode ignores it under flush. Main and skid pc/instr are cleared to 0. Instruction 0 is the NOP encoding.
- When out_valid=0, out_pc and out_instr hold 0.
- in_ready = (state != FULL). It is registered and depends only on state, never on out_ready or in_valid.

## Timing
- Reset values: out_valid=0, out_pc=0, out_instr=0, in_ready=1, state=EMPTY, counters=0.
- Latency: an accept at edge N gives out_valid=1 with that data after edge N.
- Throughput: 1 entry per cycle when out_ready is held high.
- When out_ready drops, at most one more entry is absorbed (into skid). in_ready falls on the following edge.
- Reset mid-operation clears all entries asynchronously. in_ready returns to 1 immediately while rst is high.
- Simultaneous flush and rst: rst wins.

## Configuration
- With IF_ID_PERF_CNT_EN defined: stall_cnt and flush_cnt ports and logic exist.
  - stall_cnt increments on each cycle with in_valid && !in_ready.
  - flush_cnt increments on each cycle with flush=1.
  - Both saturate at 32'hFFFF_FFFF.
  - Both are cleared only by rst; flush does not clear them.
- Without the macro: the ports are absent and no counter logic is generated.

## Structure
- Shared package pipe_pkg holds:
  - typedef enum for the buffer state {EMPTY, ONE, FULL}
  - constant NOP_INSTR = 32'h0
  - default widths PC_W and INSTR_W
- One sub-module, if_id_entry: a single {valid, pc, instr} register with load, clear and asynchronous reset. It is instantiated twice (main, skid).

## Test plan
- Reset then streaming: rst pulse, then in_valid=1 with pc 0,4,8,12 and out_ready=1 → out_pc is 0,4,8,12 on consecutive cycles, each one cycle after accept; in_ready stays 1.
- Backpressure: stream pc 0,4,8 and drop out_ready after pc 0 appears → pc 4 goes to skid, in_ready=0 next cycle, pc 8 held at fetch. Raise out_ready → outputs 4 then 8, in order, no loss or duplication.
- Flush while FULL: main=0x10, skid=0x14, flush=1 with in_valid=1 → next cycle out_valid=0, out_instr=0, in_ready=1, and 0x18 is not captured.
- Flush with simultaneous accept from EMPTY: in_pc=0x20, flush=1 → out_valid stays 0.
- Async reset mid-FULL: assert rst between edges → out_valid=0 and in_ready=1 before the next edge.
- With IF_ID_PERF_CNT_EN: hold in_valid=1 and out_ready=0 for 5 cycles after FULL, and flush for 2 cycles → stall_cnt=5 and flush_cnt=2.
